// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity,
// stop bit; delivers a parallel word over a valid/ack handshake with sticky error flags.
module serial_frame_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ack,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dout;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic             r_dout_valid;
    logic             r_busy;
    logic             r_perr;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_last_bit;
    logic             w_par_ok;
    logic             w_stop_edge;
    logic             w_frame_bad;
    logic             w_parity_bad;
    logic             w_good;
    logic             w_deliver;
    logic             w_overrun;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: the FSM only advances on bit strobes
    always_comb begin
        w_next_state = r_state;
        if (bit_en) begin
            case (r_state)
                S_IDLE:   if (!din) w_next_state = S_DATA;
                S_DATA:   if (w_last_bit) w_next_state = PARITY_EN ? S_PARITY : S_STOP;
                S_PARITY: w_next_state = S_STOP;
                S_STOP:   w_next_state = din ? S_IDLE : S_BREAK;
                S_BREAK:  if (din) w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Stop-edge decisions; frame error outranks parity error
    always_comb begin
        w_last_bit   = (r_cnt == CW'(WIDTH - 1));
        w_par_ok     = !PARITY_EN || !r_par;
        w_stop_edge  = bit_en && (r_state == S_STOP);
        w_frame_bad  = w_stop_edge && !din;
        w_parity_bad = w_stop_edge && din && !w_par_ok;
        w_good       = w_stop_edge && din && w_par_ok;
        w_deliver    = w_good && (!r_dout_valid || dout_ack);
        w_overrun    = w_good && r_dout_valid && !dout_ack;
    end

    // Datapath, handshake and sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_par        <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            if (bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!din) begin
                            r_cnt <= '0;
                            r_par <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {din, r_shift[WIDTH-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        r_par   <= r_par ^ din;
                    end
                    S_PARITY: r_par <= r_par ^ din;
                    default: ;
                endcase
            end

            if (w_deliver) begin
                r_dout       <= r_shift;
                r_dout_valid <= 1'b1;
            end else if (dout_ack) begin
                r_dout_valid <= 1'b0;
            end

            r_perr <= w_parity_bad | (r_perr & ~err_clr);
            r_ferr <= w_frame_bad  | (r_ferr & ~err_clr);
            r_ovr  <= w_overrun    | (r_ovr  & ~err_clr);
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed table, hand-written corner sequences and
// randomized frames compared against a frame-level behavioural model.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_en = 1'b0, din = 1'b1, dout_ack = 1'b0, err_clr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, busy, parity_err, frame_err, overrun;

    logic       bit_en_b = 1'b0, din_b = 1'b1, ack_b = 1'b0, clr_b = 1'b0;
    logic [7:0] dout_b;
    logic       valid_b, busy_b, perr_b, ferr_b, ovr_b;

    int checks = 0;
    int failures = 0;

    bit       m_valid, m_perr, m_ferr, m_ovr;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ack(dout_ack),
        .busy(busy), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .err_clr(err_clr)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) u_dut_np (
        .clk(clk), .rst(rst), .bit_en(bit_en_b), .din(din_b),
        .dout(dout_b), .dout_valid(valid_b), .dout_ack(ack_b),
        .busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .err_clr(clr_b)
    );

    typedef struct {
        logic [7:0] data;
        bit         pflip;
        bit         clr_before;
        bit         ack_before;
        bit         ack_stop;
        logic [7:0] exp_dout;
        bit         exp_valid;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_dout, input bit e_valid,
                           input bit e_perr, input bit e_ferr, input bit e_ovr, input bit e_busy);
        chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
        chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(e_perr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(e_ferr));
        chk({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    // One bit period: strobe on the first clk, three quiet clks follow
    task automatic send_bit(input logic b, input logic ack);
        din      = b;
        bit_en   = 1'b1;
        dout_ack = ack;
        @(posedge clk); #1;
        bit_en   = 1'b0;
        dout_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop, input bit ack_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit((^d) ^ pflip, 1'b0);
        send_bit(stop, ack_stop);
    endtask

    task automatic pulse_ack();
        dout_ack = 1'b1;
        @(posedge clk); #1;
        dout_ack = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_dout = '0;
    endtask

    // Frame-level reference: outcome of one complete frame on the sticky/handshake state
    task automatic model_frame(input logic [7:0] d, input bit pflip, input bit stop, input bit ack_stop);
        if (!stop) begin
            m_ferr = 1'b1;
            if (ack_stop) m_valid = 1'b0;
        end else if (pflip) begin
            m_perr = 1'b1;
            if (ack_stop) m_valid = 1'b0;
        end else if (!m_valid || ack_stop) begin
            m_dout  = d;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_dout, m_valid, m_perr, m_ferr, m_ovr, 1'b0);
    endtask

    initial begin
        logic [9:0] fb;
        logic [7:0] d;
        bit pf, st, as;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame: the leftover bits would otherwise complete a valid frame
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        chk_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int unsigned v = 0; v < 6; v++) begin
            if (tbl[v].clr_before) pulse_clr();
            if (tbl[v].ack_before) pulse_ack();
            send_frame(tbl[v].data, tbl[v].pflip, 1'b1, tbl[v].ack_stop);
            chk_all($sformatf("vec%0d", v), tbl[v].exp_dout, tbl[v].exp_valid,
                    tbl[v].exp_perr, tbl[v].exp_ferr, tbl[v].exp_ovr, 1'b0);
        end

        // Stop bit low, line held low, then released
        pulse_ack();
        pulse_clr();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        chk_all("break.stop", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0, 1'b0);
            chk($sformatf("break.hold%0d.busy", i), 32'(busy), 32'd1);
        end
        send_bit(1'b1, 1'b0);
        chk_all("break.release", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0);
        chk_all("break.next", 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the frame-level model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom_range(255));
            pf = ($urandom_range(3) == 0);
            st = ($urandom_range(5) != 0);
            as = ($urandom_range(3) == 0);
            if ($urandom_range(4) == 0) pulse_clr();
            if ($urandom_range(1) == 0) pulse_ack();
            repeat ($urandom_range(2)) send_bit(1'b1, 1'b0);
            send_frame(d, pf, st, as);
            model_frame(d, pf, st, as);
            if (!st) send_bit(1'b1, 1'b0);
            chk_model($sformatf("rand%0d", n));
        end

        // No-parity instance, strobe every clk, back-to-back frames
        bit_en_b = 1'b1;
        din_b    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            d  = (k == 0) ? 8'hFF : 8'h00;
            fb = {1'b1, d, 1'b0};
            for (int i = 0; i < 10; i++) begin
                din_b = fb[i];
                ack_b = (k == 1 && i == 0);
                @(posedge clk); #1;
                ack_b = 1'b0;
                if (i == 8) chk($sformatf("np%0d.early_valid", k), 32'(valid_b), 32'd0);
                if (i == 9) begin
                    chk($sformatf("np%0d.lat10_valid", k), 32'(valid_b), 32'd1);
                    chk($sformatf("np%0d.dout", k), 32'(dout_b), 32'(d));
                end
            end
        end
        din_b = 1'b1;
        ack_b = 1'b1;
        @(posedge clk); #1;
        ack_b = 1'b0;
        chk("np.final_valid", 32'(valid_b), 32'd0);
        chk("np.errors", 32'({perr_b, ferr_b, ovr_b, busy_b}), 32'd0);
        bit_en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
